// File: rtl/cacheline_adapter.sv
// Line-to-burst adapter: one full cacheline request is serialized into BEATS narrow
// memory beats; read beats are assembled into a line and a one-cycle line_resp ends each transfer.
module cacheline_adapter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [ADDR_WIDTH-1:0] line_addr,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic                  line_resp,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_addr,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic                  burst_resp,
    input  logic [BEAT_WIDTH-1:0] burst_rdata
);
    localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS_W = $clog2(LINE_WIDTH / 8);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]                           state;
    logic [CNT_W-1:0]                     beat_cnt;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]     wbuf;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]     rbuf;
    logic [BEATS-1:0][BEAT_WIDTH-1:0]     rbuf_fill;
    logic                                 last_beat;
    logic [ADDR_WIDTH-1:0]                aligned_addr;

    assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
    assign aligned_addr = {line_addr[ADDR_WIDTH-1:OFFS_W], {OFFS_W{1'b0}}};

    // The final beat is merged combinationally so line_rdata is complete at the DONE edge.
    always_comb begin
        rbuf_fill           = rbuf;
        rbuf_fill[beat_cnt] = burst_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            burst_addr <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
            line_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (line_write) begin
                        burst_addr <= aligned_addr;
                        wbuf       <= line_wdata;
                        beat_cnt   <= '0;
                        state      <= WR_BURST;
                    end else if (line_read) begin
                        burst_addr <= aligned_addr;
                        beat_cnt   <= '0;
                        state      <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (burst_resp) begin
                        rbuf[beat_cnt] <= burst_rdata;
                        beat_cnt       <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            line_rdata <= rbuf_fill;
                            state      <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (burst_resp) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (last_beat) begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Control outputs decode straight from the state flops, so reset clears them immediately.
    assign line_resp   = (state == DONE);
    assign burst_read  = (state == RD_BURST);
    assign burst_write = (state == WR_BURST);
    assign burst_wdata = wbuf[beat_cnt];

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: queue-based scoreboard of expected
// read lines and write beats, with a bounded zero/multi-wait memory responder.
`timescale 1ns/1ps
module tb_cacheline_adapter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_read;
    logic          line_write;
    logic [AW-1:0] line_addr;
    logic [LW-1:0] line_wdata;
    logic          line_resp;
    logic [LW-1:0] line_rdata;
    logic          burst_read;
    logic          burst_write;
    logic [AW-1:0] burst_addr;
    logic [BW-1:0] burst_wdata;
    logic          burst_resp;
    logic [BW-1:0] burst_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [LW-1:0] exp_line_q[$];
    logic [BW-1:0] exp_beat_q[$];
    logic [LW-1:0] last_line;

    cacheline_adapter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .line_read(line_read), .line_write(line_write),
        .line_addr(line_addr), .line_wdata(line_wdata),
        .line_resp(line_resp), .line_rdata(line_rdata),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_addr(burst_addr), .burst_wdata(burst_wdata),
        .burst_resp(burst_resp), .burst_rdata(burst_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a read, serves beats with `gap` idle cycles before each, checks the returned line.
    task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int gap);
        int cyc;
        int beat;
        logic [AW-1:0] exp_addr;
        logic [LW-1:0] exp_line;
        exp_addr   = {addr[AW-1:5], 5'b0};
        line_read  = 1'b1;
        line_addr  = addr;
        exp_line_q.push_back(line);
        step();
        line_addr = $urandom;
        cyc  = 0;
        beat = 0;
        while (line_resp !== 1'b1 && cyc < 200) begin
            n_checks++;
            if (burst_read !== 1'b1 || burst_write !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_strobe: read=%b write=%b required 1/0 at cycle %0d", burst_read, burst_write, cyc);
            end
            n_checks++;
            if (burst_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL rd_addr: got %h required %h", burst_addr, exp_addr);
            end
            if (beat < 4 && (cyc % (gap + 1)) == gap) begin
                burst_resp  = 1'b1;
                burst_rdata = line[beat*BW +: BW];
                beat++;
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
            end
            step();
            cyc++;
        end
        burst_resp = 1'b0;
        line_read  = 1'b0;
        n_checks++;
        if (cyc != 4 * (gap + 1)) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d cycles required %0d", cyc, 4 * (gap + 1));
        end
        n_checks++;
        if (line_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_timeout: line_resp=%b required 1", line_resp);
        end else begin
            exp_line = exp_line_q.pop_front();
            if (line_rdata !== exp_line) begin
                n_fail++;
                $display("FAIL rd_data: got %h required %h", line_rdata, exp_line);
            end
            last_line = exp_line;
            n_checks++;
            if (burst_read !== 1'b0 || burst_write !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_done_strobe: read=%b write=%b required 0/0", burst_read, burst_write);
            end
        end
    endtask

    // Issues a write and checks each beat against the scoreboard as it is acknowledged.
    task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int gap);
        int cyc;
        int beat;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] exp_beat;
        exp_addr   = {addr[AW-1:5], 5'b0};
        line_write = 1'b1;
        line_addr  = addr;
        line_wdata = line;
        for (int i = 0; i < 4; i++) exp_beat_q.push_back(line[i*BW +: BW]);
        step();
        line_addr  = $urandom;
        line_wdata = {8{$urandom}};
        cyc  = 0;
        beat = 0;
        while (line_resp !== 1'b1 && cyc < 200) begin
            n_checks++;
            if (burst_write !== 1'b1 || burst_read !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_strobe: write=%b read=%b required 1/0 at cycle %0d", burst_write, burst_read, cyc);
            end
            n_checks++;
            if (burst_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL wr_addr: got %h required %h", burst_addr, exp_addr);
            end
            if (beat < 4 && (cyc % (gap + 1)) == gap) begin
                burst_resp = 1'b1;
                beat++;
                n_checks++;
                if (exp_beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_extra_beat: beat %0d acknowledged with no beat expected", beat);
                end else begin
                    exp_beat = exp_beat_q.pop_front();
                    if (burst_wdata !== exp_beat) begin
                        n_fail++;
                        $display("FAIL wr_beat%0d: got %h required %h", beat - 1, burst_wdata, exp_beat);
                    end
                end
            end else begin
                burst_resp = 1'b0;
            end
            step();
            cyc++;
        end
        burst_resp = 1'b0;
        line_write = 1'b0;
        n_checks++;
        if (cyc != 4 * (gap + 1) || exp_beat_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d cycles, %0d beats left, required %0d cycles, 0 left",
                     cyc, exp_beat_q.size(), 4 * (gap + 1));
            exp_beat_q.delete();
        end
        n_checks++;
        if (line_resp !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_timeout: line_resp=%b required 1", line_resp);
        end
        n_checks++;
        if (line_rdata !== last_line) begin
            n_fail++;
            $display("FAIL wr_keeps_rdata: got %h required %h", line_rdata, last_line);
        end
    endtask

    task automatic expect_idle(input string name);
        n_checks++;
        if (line_resp !== 1'b0 || burst_read !== 1'b0 || burst_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: resp/read/write=%b%b%b required 000", name, line_resp, burst_read, burst_write);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        line_read   = 1'b0;
        line_write  = 1'b0;
        line_addr   = '0;
        line_wdata  = '0;
        burst_resp  = 1'b0;
        burst_rdata = '0;
        last_line   = '0;
        step();
        step();
        expect_idle("reset_ctrl");
        n_checks++;
        if (burst_addr !== '0 || line_rdata !== '0 || burst_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h rdata=%h wdata=%h required all 0", burst_addr, line_rdata, burst_wdata);
        end
        rst_n = 1'b1;
        step();
        expect_idle("reset_release");
    endtask

    task automatic test_read();
        do_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
        step();
        expect_idle("read_single_pulse");
    endtask

    task automatic test_write();
        do_write(32'h8000_0040, {64'hDDDD_0000_DDDD_0003, 64'hCCCC_0000_CCCC_0002,
                                 64'hBBBB_0000_BBBB_0001, 64'hAAAA_0000_AAAA_0000}, 2);
        step();
        expect_idle("write_single_pulse");
    endtask

    task automatic test_both_high();
        line_read = 1'b1;
        do_write(32'h0000_5678, {4{64'h0123_4567_89AB_CDEF}}, 1);
        line_read = 1'b0;
        step();
        expect_idle("both_single_pulse");
        step();
        expect_idle("both_no_read");
    endtask

    task automatic test_stray_resp();
        for (int i = 0; i < 3; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = {$urandom, $urandom};
            step();
            expect_idle("stray_idle");
        end
        burst_resp = 1'b0;
        do_read(32'h0000_0F00, {64'h5555_AAAA_0000_0004, 64'h5555_AAAA_0000_0003,
                                64'h5555_AAAA_0000_0002, 64'h5555_AAAA_0000_0001}, 0);
        burst_resp  = 1'b1;
        burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        burst_resp = 1'b0;
        expect_idle("stray_done");
        n_checks++;
        if (line_rdata !== last_line) begin
            n_fail++;
            $display("FAIL stray_rdata: got %h required %h", line_rdata, last_line);
        end
    endtask

    task automatic test_reset_mid_burst();
        line_read = 1'b1;
        line_addr = 32'h2000_0100;
        step();
        for (int i = 0; i < 2; i++) begin
            burst_resp  = 1'b1;
            burst_rdata = 64'hDEAD_0000_0000_0000 | 64'(i);
            step();
        end
        burst_resp = 1'b0;
        n_checks++;
        if (burst_read !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre: burst_read=%b required 1", burst_read);
        end
        rst_n = 1'b0;
        #1;
        line_read = 1'b0;
        expect_idle("midrst_async");
        n_checks++;
        if (line_rdata !== '0 || burst_addr !== '0) begin
            n_fail++;
            $display("FAIL midrst_data: rdata=%h addr=%h required 0", line_rdata, burst_addr);
        end
        last_line = '0;
        step();
        rst_n = 1'b1;
        step();
        step();
        expect_idle("midrst_wait_idle");
        do_read(32'h2000_0120, {64'h0B0B_0000_0000_0004, 64'h0B0B_0000_0000_0003,
                                64'h0B0B_0000_0000_0002, 64'h0B0B_0000_0000_0001}, 1);
        step();
        expect_idle("midrst_new_read_done");
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] wline;
        wline = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
                 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
        do_read(32'h0000_3000, {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001}, 0);
        line_write = 1'b1;
        line_addr  = 32'h4000_0060;
        line_wdata = wline;
        step();
        expect_idle("b2b_gap_cycle");
        do_write(32'h4000_0060, wline, 0);
        step();
        expect_idle("b2b_end");
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_both_high();
        test_stray_resp();
        test_reset_mid_burst();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
